// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a stored song by driving note_decoder's note/enable inputs. A small
//   writable table holds (note, duration) steps; on start the sequencer walks
//   steps 0..last_addr, holding each note for dur*TICK_DIV cycles, then a
//   GAP_CYC-cycle articulation gap. It can loop back to step 0 at the end.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   wr_en      in   write one table entry this cycle
//   wr_addr    in   [AW]  entry index to write
//   wr_note    in   [10]  note number (0 or >88 = rest)
//   wr_dur     in   [8]   duration in ticks (0 treated as 1)
//   last_addr  in   [AW]  final step index, latched when start is accepted
//   loop       in   replay from step 0 after the last step (sampled live)
//   start      in   begin playback (accepted only in IDLE)
//   stop       in   abort playback
//   note_out   out  [10]  note number to note_decoder
//   note_en    out  enable to note_decoder
//   busy       out  high whenever not IDLE
//   step_idx   out  [AW]  current step
//   done       out  one-cycle pulse when a non-looping song ends
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; note_en low
// FETCH | one cycle: load table[step_idx] into note_out and tick counter
// PLAY  | note held for dur*TICK_DIV cycles (note_en high unless a rest)
// GAP   | GAP_CYC cycles with note_en low, then advance / loop / finish

module note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 1000,
  parameter int GAP_CYC  = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [9:0]    wr_note,
  input  logic [7:0]    wr_dur,
  input  logic [AW-1:0] last_addr,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [9:0]    note_out,
  output logic          note_en,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

  logic [17:0]   song [DEPTH];
  logic [1:0]    state;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    tick_cnt;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] last_q;

  logic [17:0]   fetch_word;
  logic [9:0]    fetch_note;
  logic [7:0]    fetch_dur;

  // Combinational read of the current step; a same-cycle write only lands
  // at the clock edge, so FETCH always sees the old contents.
  assign fetch_word = song[step_idx];
  assign fetch_note = fetch_word[17:8];
  assign fetch_dur  = fetch_word[7:0];

  // Song table has no reset: contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wr_en) song[wr_addr] <= {wr_note, wr_dur};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      note_out <= '0;
      note_en  <= 1'b0;
      busy     <= 1'b0;
      step_idx <= '0;
      done     <= 1'b0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      last_q   <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // note_out and step_idx deliberately hold their values.
        state   <= S_IDLE;
        busy    <= 1'b0;
        note_en <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_FETCH;
              busy     <= 1'b1;
              step_idx <= '0;
              last_q   <= last_addr;
            end
          end
          S_FETCH: begin
            note_out <= fetch_note;
            note_en  <= (fetch_note != 10'd0) && (fetch_note <= 10'd88);
            // Tick counter counts remaining ticks after the current one,
            // so a zero duration plays exactly like a duration of one.
            tick_cnt <= (fetch_dur == 8'd0) ? 8'd0 : fetch_dur - 8'd1;
            pre_cnt  <= PRE_LOAD;
            state    <= S_PLAY;
          end
          S_PLAY: begin
            if (pre_cnt == '0) begin
              if (tick_cnt == 8'd0) begin
                state   <= S_GAP;
                note_en <= 1'b0;
                gap_cnt <= GAP_LOAD;
              end else begin
                tick_cnt <= tick_cnt - 8'd1;
                pre_cnt  <= PRE_LOAD;
              end
            end else begin
              pre_cnt <= pre_cnt - 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) begin
              if (step_idx != last_q) begin
                step_idx <= step_idx + 1'b1;
                state    <= S_FETCH;
              end else if (loop) begin
                step_idx <= '0;
                state    <= S_FETCH;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: each playback request expands the
// song (from a shadow copy of the table) into the expected per-cycle output
// trace and queues it; a monitor pops one entry per cycle at the falling edge.
module tb_note_sequencer;

  localparam int TICK = 10;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [9:0] wr_note = '0;
  logic [7:0] wr_dur = '0;
  logic [3:0] last_addr = '0;
  logic       loop = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [9:0] note_out;
  logic       note_en;
  logic       busy;
  logic [3:0] step_idx;
  logic       done;

  note_sequencer #(.DEPTH(16), .TICK_DIV(TICK), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note(wr_note), .wr_dur(wr_dur), .last_addr(last_addr), .loop(loop),
    .start(start), .stop(stop), .note_out(note_out), .note_en(note_en),
    .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       en;
    logic       done;
    logic [9:0] note;
    logic [3:0] idx;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   tbl_note[16];
  int   tbl_dur[16];
  int   m_note = 0;
  int   m_idx = 0;

  function automatic exp_t mk(input bit b, input bit en, input bit dn,
                              input int n, input int i);
    exp_t r;
    r.busy = b; r.en = en; r.done = dn; r.note = 10'(n); r.idx = 4'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if ({busy, note_en, done, note_out, step_idx} !== e) begin
        errors++;
        $display("FAIL trace t=%0t: got busy=%b en=%b done=%b note=%0d idx=%0d, want busy=%b en=%b done=%b note=%0d idx=%0d",
                 $time, busy, note_en, done, note_out, step_idx,
                 e.busy, e.en, e.done, e.note, e.idx);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // All tasks are entered just after a rising edge (posedge + 1).
  task automatic wr(input int a, input int n, input int d, input bit upd);
    wr_en = 1'b1; wr_addr = 4'(a); wr_note = 10'(n); wr_dur = 8'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (upd) begin tbl_note[a] = n; tbl_dur[a] = d; end
  endtask

  task automatic drain();
    int b = 0;
    while (expq.size() != 0) begin
      @(posedge clk);
      b++;
      if (b > 5000) begin
        checks++; errors++;
        $display("FAIL drain timeout: %0d entries left, want 0", expq.size());
        expq.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  // kind: 0 = play to the end, 1 = stop after cut cycles, 2 = reset after cut
  // cycles (cut = 0 with kind != 0 picks a random point while busy).
  // passes > 1 expects loop = 1 from the caller; it is dropped mid last pass.
  task automatic launch(input int last, input int passes, input int cut,
                        input int kind, input int tail);
    exp_t q[$];
    exp_t e;
    int   pn, nt, d, plen;
    bit   v;
    last_addr = 4'(last);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pn = m_note;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k <= last; k++) begin
        q.push_back(mk(1, 0, 0, pn, k));
        nt = tbl_note[k];
        d  = (tbl_dur[k] == 0) ? 1 : tbl_dur[k];
        v  = (nt >= 1 && nt <= 88);
        for (int c = 0; c < d * TICK; c++) q.push_back(mk(1, v, 0, nt, k));
        for (int c = 0; c < GAP; c++) q.push_back(mk(1, 0, 0, nt, k));
        pn = nt;
      end
    end
    plen = q.size() / passes;
    q.push_back(mk(0, 0, 1, pn, last));
    if (kind != 0) begin
      if (cut == 0) cut = $urandom_range(1, q.size() - 1);
      e = q[cut-1];
      while (q.size() > cut) void'(q.pop_back());
      if (kind == 1) q.push_back(mk(0, 0, 0, e.note, e.idx));
      else           q.push_back(mk(0, 0, 0, 0, 0));
    end
    e = q[q.size()-1];
    for (int i = 0; i < tail; i++) q.push_back(mk(0, 0, 0, e.note, e.idx));
    m_note = e.note;
    m_idx  = e.idx;
    foreach (q[i]) expq.push_back(q[i]);
    if (kind != 0) begin
      repeat (cut - 1) @(posedge clk);
      #1;
      if (kind == 1) stop = 1'b1; else reset = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0; reset = 1'b0;
    end else if (passes > 1) begin
      repeat ((passes - 1) * plen + 3) @(posedge clk);
      #1;
      loop = 1'b0;
    end
  endtask

  initial begin
    int last, mode, n;
    repeat (3) @(posedge clk);
    #1;
    expq.push_back(mk(0, 0, 0, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    drain();

    // Basic play.
    wr(0, 1, 2, 1); wr(1, 12, 1, 1); wr(2, 88, 3, 1);
    launch(2, 1, 0, 0, 3);
    drain();

    // Rest and out-of-range notes.
    wr(0, 0, 1, 1); wr(1, 100, 1, 1);
    launch(1, 1, 0, 0, 2);
    drain();

    // Zero duration.
    wr(0, 5, 0, 1);
    launch(0, 1, 0, 0, 2);
    drain();

    // Loop, dropped during the second pass.
    wr(0, 40, 1, 1); wr(1, 41, 2, 1);
    loop = 1'b1;
    launch(1, 2, 0, 0, 2);
    loop = 1'b0;
    drain();

    // Stop mid-PLAY.
    wr(0, 30, 2, 1); wr(1, 31, 1, 1); wr(2, 32, 1, 1);
    launch(2, 1, 6, 1, 3);
    drain();

    // start together with stop in IDLE: must stay idle.
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) expq.push_back(mk(0, 0, 0, m_note, m_idx));
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    drain();

    // Reset mid-PLAY.
    launch(2, 1, 8, 2, 3);
    drain();

    // Live writes: same-address write during FETCH keeps the old note,
    // a later step rewritten during playback plays the new note.
    wr(0, 20, 1, 1); wr(1, 21, 1, 1); wr(2, 22, 1, 1);
    tbl_note[2] = 77; tbl_dur[2] = 2;
    launch(2, 1, 0, 0, 2);
    wr(0, 60, 3, 0);
    wr(2, 77, 2, 0);
    tbl_note[0] = 60; tbl_dur[0] = 3;
    drain();
    launch(0, 1, 0, 0, 2);
    drain();

    // Randomized songs.
    for (int it = 0; it < 30; it++) begin
      last = $urandom_range(0, 4);
      for (int a = 0; a <= last; a++) begin
        mode = $urandom_range(0, 9);
        if (mode == 0)      n = 0;
        else if (mode == 1) n = $urandom_range(89, 1023);
        else                n = $urandom_range(1, 88);
        wr(a, n, $urandom_range(0, 3), 1);
      end
      mode = $urandom_range(0, 7);
      if (mode == 6) begin
        launch(last, 1, 0, 1, 2);
      end else if (mode == 7) begin
        loop = 1'b1;
        launch(last, 2, 0, 0, 2);
        loop = 1'b0;
      end else begin
        launch(last, 1, 0, 0, 2);
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
